// File: rtl/ibex_pkg.sv
// Shared types for the iterative multiplier/divider: operator encoding and FSM states.
package ibex_pkg;

  typedef enum logic [1:0] {
    MD_OP_MULL = 2'b00,
    MD_OP_MULH = 2'b01,
    MD_OP_DIV  = 2'b10,
    MD_OP_REM  = 2'b11
  } md_op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ABS  = 3'd1,
    COMP = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } md_fsm_e;

  function automatic logic is_mul(input md_op_e op);
    return (op == MD_OP_MULL) || (op == MD_OP_MULH);
  endfunction

endpackage

// File: rtl/ibex_multdiv_iter_step.sv
// One add/subtract step shared by multiply (shift-add) and divide (restoring compare).
module ibex_multdiv_iter_step #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             en_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  logic [WIDTH-1:0] operand_s;
  logic [WIDTH-1:0] addend_s;

  // With en_i low and sub_i high the result is a_i with carry set, i.e. "a >= 0".
  assign operand_s = en_i ? b_i : {WIDTH{1'b0}};
  assign addend_s  = sub_i ? ~operand_s : operand_s;
  assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, addend_s} + {{WIDTH{1'b0}}, sub_i};

endmodule

// File: rtl/ibex_multdiv_iter.sv
// Iterative multiply/divide unit retiring BITS_PER_CYCLE bits per COMP cycle.
module ibex_multdiv_iter import ibex_pkg::*; #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             CK,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             kill_i,
  input  logic [1:0]       operator_i,
  input  logic [1:0]       signed_mode_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             ready_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int unsigned N  = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CW = $clog2(N);
  localparam int unsigned DW = 2 * WIDTH;

  md_fsm_e          state_r;
  md_op_e           op_r;
  md_op_e           op_in_s;
  logic             sign_a_r, sign_b_r, sign_a_in_s, sign_b_in_s;
  logic [DW-1:0]    acc_r, opa_r;
  logic [WIDTH-1:0] opb_r, result_r;
  logic [CW-1:0]    cnt_r;
  logic             valid_r, busy_r, is_mul_s;

  assign op_in_s     = md_op_e'(operator_i);
  assign sign_a_in_s = op_a_i[WIDTH-1] & signed_mode_i[0];
  assign sign_b_in_s = op_b_i[WIDTH-1] & signed_mode_i[1];
  assign is_mul_s    = is_mul(op_r);

  // Divide keeps {remainder, quotient/dividend} in acc_r; multiply keeps the running product.
  logic [DW-1:0]    acc_chain_s [BITS_PER_CYCLE+1];
  logic [WIDTH-1:0] rem_chain_s [BITS_PER_CYCLE+1];
  logic [WIDTH-1:0] quo_chain_s [BITS_PER_CYCLE+1];

  assign acc_chain_s[0] = acc_r;
  assign rem_chain_s[0] = acc_r[DW-1:WIDTH];
  assign quo_chain_s[0] = acc_r[WIDTH-1:0];

  for (genvar j = 0; j < BITS_PER_CYCLE; j++) begin : g_step
    localparam bit LastStep = (j == int'(BITS_PER_CYCLE) - 1);
    logic [DW-1:0] a_s, b_s, sum_s;
    logic          en_s, sub_s, carry_s;

    // The multiplier MSB carries negative weight when op_b is signed.
    assign a_s   = is_mul_s ? acc_chain_s[j]
                            : {{(WIDTH-1){1'b0}}, rem_chain_s[j], quo_chain_s[j][WIDTH-1]};
    assign b_s   = is_mul_s ? (opa_r << j) : {{WIDTH{1'b0}}, opb_r};
    assign en_s  = is_mul_s ? opb_r[j] : 1'b1;
    assign sub_s = is_mul_s ? (LastStep && sign_b_r && (cnt_r == {CW{1'b0}})) : 1'b1;

    ibex_multdiv_iter_step #(.WIDTH(DW)) u_step (
      .a_i    (a_s),
      .b_i    (b_s),
      .en_i   (en_s),
      .sub_i  (sub_s),
      .sum_o  (sum_s),
      .carry_o(carry_s)
    );

    assign acc_chain_s[j+1] = sum_s;
    assign rem_chain_s[j+1] = carry_s ? sum_s[WIDTH-1:0] : a_s[WIDTH-1:0];
    assign quo_chain_s[j+1] = {quo_chain_s[j][WIDTH-2:0], carry_s};
  end

  // Control FSM and datapath registers.
  always_ff @(posedge CK or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r  <= IDLE;
      op_r     <= MD_OP_MULL;
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      acc_r    <= {DW{1'b0}};
      opa_r    <= {DW{1'b0}};
      opb_r    <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
      result_r <= {WIDTH{1'b0}};
      valid_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else if (kill_i) begin
      state_r  <= IDLE;
      result_r <= {WIDTH{1'b0}};
      valid_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_i) begin
            op_r     <= op_in_s;
            sign_a_r <= sign_a_in_s;
            sign_b_r <= sign_b_in_s;
            cnt_r    <= CW'(N - 1);
            busy_r   <= 1'b1;
            if (is_mul(op_in_s)) begin
              acc_r   <= {DW{1'b0}};
              opa_r   <= {{WIDTH{sign_a_in_s}}, op_a_i};
              opb_r   <= op_b_i;
              state_r <= COMP;
            end else if (op_b_i == {WIDTH{1'b0}}) begin
              result_r <= (op_in_s == MD_OP_DIV) ? {WIDTH{1'b1}} : op_a_i;
              valid_r  <= 1'b1;
              state_r  <= DONE;
            end else begin
              acc_r   <= {{WIDTH{1'b0}}, op_a_i};
              opb_r   <= op_b_i;
              state_r <= ABS;
            end
          end
        end
        ABS: begin
          acc_r   <= {{WIDTH{1'b0}}, sign_a_r ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0]};
          opb_r   <= sign_b_r ? -opb_r : opb_r;
          state_r <= COMP;
        end
        COMP: begin
          acc_r <= is_mul_s ? acc_chain_s[BITS_PER_CYCLE]
                            : {rem_chain_s[BITS_PER_CYCLE], quo_chain_s[BITS_PER_CYCLE]};
          opa_r <= opa_r << BITS_PER_CYCLE;
          opb_r <= is_mul_s ? (opb_r >> BITS_PER_CYCLE) : opb_r;
          if (cnt_r == {CW{1'b0}}) begin
            if (is_mul_s) begin
              result_r <= (op_r == MD_OP_MULH) ? acc_chain_s[BITS_PER_CYCLE][DW-1:WIDTH]
                                               : acc_chain_s[BITS_PER_CYCLE][WIDTH-1:0];
              valid_r  <= 1'b1;
              state_r  <= DONE;
            end else begin
              state_r <= FIX;
            end
          end else begin
            cnt_r <= cnt_r - 1'b1;
          end
        end
        FIX: begin
          if (op_r == MD_OP_DIV) begin
            result_r <= (sign_a_r ^ sign_b_r) ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0];
          end else begin
            result_r <= sign_a_r ? -acc_r[DW-1:WIDTH] : acc_r[DW-1:WIDTH];
          end
          valid_r <= 1'b1;
          state_r <= DONE;
        end
        DONE: begin
          if (ready_i) begin
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy_o   = busy_r;
  assign valid_o  = valid_r;
  assign result_o = result_r;

endmodule

// File: tb/tb_ibex_multdiv_iter.sv
// Directed bench driving three instances (1, 2 and 4 bits per cycle) with shared stimulus.
module tb_ibex_multdiv_iter;
  import ibex_pkg::*;

  localparam int W = 32;

  logic           ck = 1'b0;
  logic           rst_ni, start_i, kill_i, ready_i;
  logic [1:0]     operator_i, signed_mode_i;
  logic [W-1:0]   op_a_i, op_b_i;
  logic           busy_o   [3];
  logic           valid_o  [3];
  logic [W-1:0]   result_o [3];
  logic           vseen;
  int             total = 0;
  int             bad   = 0;

  always #5 ck = ~ck;

  ibex_multdiv_iter #(.WIDTH(W), .BITS_PER_CYCLE(1)) u_dut1 (
    .CK(ck), .rst_ni(rst_ni), .start_i(start_i), .kill_i(kill_i), .operator_i(operator_i),
    .signed_mode_i(signed_mode_i), .op_a_i(op_a_i), .op_b_i(op_b_i), .ready_i(ready_i),
    .busy_o(busy_o[0]), .valid_o(valid_o[0]), .result_o(result_o[0]));
  ibex_multdiv_iter #(.WIDTH(W), .BITS_PER_CYCLE(2)) u_dut2 (
    .CK(ck), .rst_ni(rst_ni), .start_i(start_i), .kill_i(kill_i), .operator_i(operator_i),
    .signed_mode_i(signed_mode_i), .op_a_i(op_a_i), .op_b_i(op_b_i), .ready_i(ready_i),
    .busy_o(busy_o[1]), .valid_o(valid_o[1]), .result_o(result_o[1]));
  ibex_multdiv_iter #(.WIDTH(W), .BITS_PER_CYCLE(4)) u_dut4 (
    .CK(ck), .rst_ni(rst_ni), .start_i(start_i), .kill_i(kill_i), .operator_i(operator_i),
    .signed_mode_i(signed_mode_i), .op_a_i(op_a_i), .op_b_i(op_b_i), .ready_i(ready_i),
    .busy_o(busy_o[2]), .valid_o(valid_o[2]), .result_o(result_o[2]));

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // kind: 0 multiply, 1 divide, 2 divide by zero; instance d retires 2**d bits per cycle
  function automatic int exp_lat(input int d, input int kind);
    int n;
    n = W / (1 << d);
    if (kind == 0) return n + 1;
    else if (kind == 1) return n + 3;
    else return 1;
  endfunction

  task automatic do_op(input string tag, input logic [1:0] op, input logic [1:0] sm,
                       input logic [W-1:0] a, input logic [W-1:0] b, input int kind,
                       input logic [W-1:0] exp_res);
    int           lat [3];
    logic [W-1:0] res [3];
    for (int d = 0; d < 3; d++) begin
      lat[d] = 0;
      res[d] = '0;
    end
    @(negedge ck);
    operator_i = op; signed_mode_i = sm; op_a_i = a; op_b_i = b; start_i = 1'b1;
    @(posedge ck); #1;
    start_i = 1'b0; operator_i = ~op; signed_mode_i = ~sm; op_a_i = ~a; op_b_i = b + 32'd1;
    for (int c = 1; c <= 40; c++) begin
      for (int d = 0; d < 3; d++) begin
        if (lat[d] == 0 && valid_o[d]) begin
          lat[d] = c;
          res[d] = result_o[d];
        end
      end
      @(posedge ck); #1;
    end
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s lat k%0d", tag, 1 << d), 32'(lat[d]), 32'(exp_lat(d, kind)));
      chk($sformatf("%s res k%0d", tag, 1 << d), res[d], exp_res);
    end
  endtask

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; kill_i = 1'b0; ready_i = 1'b1;
    operator_i = 2'b00; signed_mode_i = 2'b00; op_a_i = '0; op_b_i = '0;
    repeat (2) @(posedge ck);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst busy k%0d", 1 << d), {31'b0, busy_o[d]}, 32'h0);
      chk($sformatf("rst valid k%0d", 1 << d), {31'b0, valid_o[d]}, 32'h0);
      chk($sformatf("rst result k%0d", 1 << d), result_o[d], 32'h0);
    end
    @(negedge ck); rst_ni = 1'b1;

    do_op("mull_ss", MD_OP_MULL, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'h0000_0001);
    do_op("mulhsu", MD_OP_MULH, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF);
    do_op("mulhu", MD_OP_MULH, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFE);
    do_op("mulh_ss", MD_OP_MULH, 2'b11, 32'h8000_0000, 32'h8000_0000, 0, 32'h4000_0000);
    do_op("mull_uu", MD_OP_MULL, 2'b00, 32'h1234_5678, 32'h0000_0010, 0, 32'h2345_6780);
    do_op("div_s", MD_OP_DIV, 2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 1, 32'hFFFF_FFFD);
    do_op("rem_s", MD_OP_REM, 2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 1, 32'hFFFF_FFFF);
    do_op("div_negb", MD_OP_DIV, 2'b11, 32'h0000_0007, 32'hFFFF_FFFE, 1, 32'hFFFF_FFFD);
    do_op("rem_negb", MD_OP_REM, 2'b11, 32'h0000_0007, 32'hFFFF_FFFE, 1, 32'h0000_0001);
    do_op("divu", MD_OP_DIV, 2'b00, 32'd100, 32'd7, 1, 32'd14);
    do_op("remu", MD_OP_REM, 2'b00, 32'd100, 32'd7, 1, 32'd2);
    do_op("div0", MD_OP_DIV, 2'b00, 32'h0000_1234, 32'h0, 2, 32'hFFFF_FFFF);
    do_op("rem0", MD_OP_REM, 2'b00, 32'h0000_1234, 32'h0, 2, 32'h0000_1234);
    do_op("div_ovf", MD_OP_DIV, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
    do_op("rem_ovf", MD_OP_REM, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0000_0000);

    // Result held while the consumer stalls; a start with ready is ignored.
    ready_i = 1'b0;
    @(negedge ck);
    operator_i = MD_OP_MULL; signed_mode_i = 2'b00; op_a_i = 32'd6; op_b_i = 32'd7; start_i = 1'b1;
    @(posedge ck); #1; start_i = 1'b0;
    repeat (39) @(posedge ck);
    #1;
    for (int i = 0; i < 5; i++) begin
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("hold valid k%0d c%0d", 1 << d, i), {31'b0, valid_o[d]}, 32'h1);
        chk($sformatf("hold res k%0d c%0d", 1 << d, i), result_o[d], 32'd42);
      end
      @(posedge ck); #1;
    end
    ready_i = 1'b1; start_i = 1'b1;
    @(posedge ck); #1; start_i = 1'b0;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("release busy k%0d", 1 << d), {31'b0, busy_o[d]}, 32'h0);
      chk($sformatf("release valid k%0d", 1 << d), {31'b0, valid_o[d]}, 32'h0);
    end

    // Kill in COMP cycle 10, together with a start that must lose.
    vseen = 1'b0;
    @(negedge ck);
    operator_i = MD_OP_MULL; signed_mode_i = 2'b00; op_a_i = 32'd5; op_b_i = 32'd3; start_i = 1'b1;
    @(posedge ck); #1; start_i = 1'b0;
    for (int c = 1; c < 10; c++) begin
      vseen = vseen | valid_o[0] | valid_o[1];
      @(posedge ck); #1;
    end
    vseen = vseen | valid_o[0] | valid_o[1];
    kill_i = 1'b1; start_i = 1'b1;
    @(posedge ck); #1; kill_i = 1'b0; start_i = 1'b0;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("kill busy k%0d", 1 << d), {31'b0, busy_o[d]}, 32'h0);
      chk($sformatf("kill valid k%0d", 1 << d), {31'b0, valid_o[d]}, 32'h0);
    end
    for (int c = 0; c < 40; c++) begin
      vseen = vseen | valid_o[0] | valid_o[1] | valid_o[2];
      @(posedge ck); #1;
    end
    chk("kill valid_seen", {31'b0, vseen}, 32'h0);
    do_op("after_kill", MD_OP_MULL, 2'b00, 32'd5, 32'd3, 0, 32'd15);

    // Asynchronous reset in the middle of a divide.
    @(negedge ck);
    operator_i = MD_OP_DIV; signed_mode_i = 2'b11; op_a_i = 32'd1000; op_b_i = 32'd3; start_i = 1'b1;
    @(posedge ck); #1; start_i = 1'b0;
    repeat (5) @(posedge ck);
    #3; rst_ni = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("midrst busy k%0d", 1 << d), {31'b0, busy_o[d]}, 32'h0);
      chk($sformatf("midrst result k%0d", 1 << d), result_o[d], 32'h0);
    end
    @(negedge ck); rst_ni = 1'b1;
    do_op("after_rst", MD_OP_DIV, 2'b11, 32'd100, 32'd7, 1, 32'd14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
